// File: rtl/cache_bank_arbiter_if.sv
// Request/response bundle between the cache control/fill logic and the bank arbiter:
// one write requester and four read ports.
interface cache_bank_arbiter_if #(
  parameter int ADR = 4,
  parameter int DAT = 32
);
  logic           wrReq;
  logic [ADR-1:0] wrAddr;
  logic [DAT-1:0] wrData;
  logic           wrAck;
  logic [3:0]     rdReq;
  logic [ADR-1:0] rdAddr_0;
  logic [ADR-1:0] rdAddr_1;
  logic [ADR-1:0] rdAddr_2;
  logic [ADR-1:0] rdAddr_3;
  logic [3:0]     rdAck;
  logic [3:0]     rdValid;
  logic [DAT-1:0] rdData_0;
  logic [DAT-1:0] rdData_1;
  logic [DAT-1:0] rdData_2;
  logic [DAT-1:0] rdData_3;

  modport master (
    output wrReq, wrAddr, wrData, rdReq, rdAddr_0, rdAddr_1, rdAddr_2, rdAddr_3,
    input  wrAck, rdAck, rdValid, rdData_0, rdData_1, rdData_2, rdData_3
  );

  modport slave (
    input  wrReq, wrAddr, wrData, rdReq, rdAddr_0, rdAddr_1, rdAddr_2, rdAddr_3,
    output wrAck, rdAck, rdValid, rdData_0, rdData_1, rdData_2, rdData_3
  );
endinterface

// File: rtl/cache_bank_arbiter.sv
// Single-bank syncRAM sequencer: one RAM command per cycle, a write or a shared read
// serving every pending read port, with a bounded wait so reads cannot starve the writer.
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module cache_bank_arbiter #(
  parameter int ADR         = `CACHE_BANK_ADDRESS_WIDTH,
  parameter int DAT         = `DATA_WIDTH,
  parameter int WR_WAIT_MAX = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  cache_bank_arbiter_if.slave bus,
  output logic               ramChipSelect,
  output logic               ramWriteEnable,
  output logic               ramReadEnable,
  output logic [ADR-1:0]     ramWriteAddr,
  output logic [DAT-1:0]     ramDataIn,
  output logic [ADR-1:0]     ramReadAddr_0,
  output logic [ADR-1:0]     ramReadAddr_1,
  output logic [ADR-1:0]     ramReadAddr_2,
  output logic [ADR-1:0]     ramReadAddr_3,
  input  logic [DAT-1:0]     ramDOut_0,
  input  logic [DAT-1:0]     ramDOut_1,
  input  logic [DAT-1:0]     ramDOut_2,
  input  logic [DAT-1:0]     ramDOut_3
);
  localparam int WW = $clog2(WR_WAIT_MAX + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t         state_p1, stateNext;
  logic [WW-1:0]  wrWait, wrWaitNext;
  logic [3:0]     grant_p1, grantNext;
  logic [3:0]     vld_p2;
  logic           wPend;
  logic [3:0]     pPend;
  logic [ADR-1:0] rdAddrIn [4];
  logic [ADR-1:0] rdAddr_p1 [4];
  logic [ADR-1:0] wrAddr_p1;
  logic [DAT-1:0] wrData_p1;

  function automatic logic [WW-1:0] satInc(input logic [WW-1:0] v);
    if (v >= WW'(WR_WAIT_MAX)) return WW'(WR_WAIT_MAX);
    return v + WW'(1);
  endfunction

  assign rdAddrIn[0] = bus.rdAddr_0;
  assign rdAddrIn[1] = bus.rdAddr_1;
  assign rdAddrIn[2] = bus.rdAddr_2;
  assign rdAddrIn[3] = bus.rdAddr_3;

  // Decision: requesters still in their ack cycle are masked out of the pending sets
  always_comb begin
    wPend      = bus.wrReq & (state_p1 != WRITE);
    pPend      = bus.rdReq & ~grant_p1;
    stateNext  = IDLE;
    grantNext  = '0;
    wrWaitNext = '0;
    if (wPend && (wrWait == WW'(WR_WAIT_MAX))) begin
      stateNext = WRITE;
    end else if (pPend != 4'b0000) begin
      stateNext = READ;
      grantNext = pPend;
      if (wPend) wrWaitNext = satInc(wrWait);
    end else if (wPend) begin
      stateNext = WRITE;
    end
  end

  // Command stage (p1) and read-data-valid stage (p2)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_p1  <= IDLE;
      grant_p1  <= '0;
      vld_p2    <= '0;
      wrWait    <= '0;
      wrAddr_p1 <= '0;
      wrData_p1 <= '0;
      for (int i = 0; i < 4; i++) rdAddr_p1[i] <= '0;
    end else begin
      state_p1 <= stateNext;
      grant_p1 <= grantNext;
      vld_p2   <= grant_p1;
      wrWait   <= wrWaitNext;
      if (stateNext == WRITE) begin
        wrAddr_p1 <= bus.wrAddr;
        wrData_p1 <= bus.wrData;
      end
      for (int i = 0; i < 4; i++) begin
        if (grantNext[i]) rdAddr_p1[i] <= rdAddrIn[i];
      end
    end
  end

  assign ramChipSelect  = (state_p1 != IDLE);
  assign ramWriteEnable = (state_p1 == WRITE);
  assign ramReadEnable  = (state_p1 == READ);
  assign ramWriteAddr   = wrAddr_p1;
  assign ramDataIn      = wrData_p1;
  assign ramReadAddr_0  = rdAddr_p1[0];
  assign ramReadAddr_1  = rdAddr_p1[1];
  assign ramReadAddr_2  = rdAddr_p1[2];
  assign ramReadAddr_3  = rdAddr_p1[3];

  assign bus.wrAck    = (state_p1 == WRITE);
  assign bus.rdAck    = grant_p1;
  assign bus.rdValid  = vld_p2;
  assign bus.rdData_0 = ramDOut_0;
  assign bus.rdData_1 = ramDOut_1;
  assign bus.rdData_2 = ramDOut_2;
  assign bus.rdData_3 = ramDOut_3;
endmodule

// File: tb/tb_cache_bank_arbiter.sv
// Directed bench for cache_bank_arbiter with a behavioural syncRAM behind it;
// a vector table covers steady traffic, hand sequences cover reset corners.
module tb_cache_bank_arbiter;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        ramChipSelect, ramWriteEnable, ramReadEnable;
  logic [3:0]  ramWriteAddr;
  logic [31:0] ramDataIn;
  logic [3:0]  ramReadAddr_0, ramReadAddr_1, ramReadAddr_2, ramReadAddr_3;
  logic [31:0] ramDOut_0, ramDOut_1, ramDOut_2, ramDOut_3;
  logic [31:0] mem [16];

  int total = 0;
  int bad   = 0;

  cache_bank_arbiter_if #(.ADR(4), .DAT(32)) bus ();

  cache_bank_arbiter #(.ADR(4), .DAT(32), .WR_WAIT_MAX(3)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus),
    .ramChipSelect(ramChipSelect), .ramWriteEnable(ramWriteEnable), .ramReadEnable(ramReadEnable),
    .ramWriteAddr(ramWriteAddr), .ramDataIn(ramDataIn),
    .ramReadAddr_0(ramReadAddr_0), .ramReadAddr_1(ramReadAddr_1),
    .ramReadAddr_2(ramReadAddr_2), .ramReadAddr_3(ramReadAddr_3),
    .ramDOut_0(ramDOut_0), .ramDOut_1(ramDOut_1), .ramDOut_2(ramDOut_2), .ramDOut_3(ramDOut_3)
  );

  always #5 Clk = ~Clk;

  // Behavioural bank RAM: registered read on every port
  always @(posedge Clk) begin
    if (ramChipSelect && ramWriteEnable) mem[ramWriteAddr] <= ramDataIn;
    if (ramChipSelect && ramReadEnable) begin
      ramDOut_0 <= mem[ramReadAddr_0];
      ramDOut_1 <= mem[ramReadAddr_1];
      ramDOut_2 <= mem[ramReadAddr_2];
      ramDOut_3 <= mem[ramReadAddr_3];
    end
  end

  typedef struct {
    logic         wrReq;
    logic [3:0]   wrAddr;
    logic [31:0]  wrData;
    logic [3:0]   rdReq;
    logic [15:0]  rdA;
    logic         eWe;
    logic         eRe;
    logic [3:0]   eAck;
    logic [3:0]   eVld;
    logic [127:0] eData;
  } vec_t;

  vec_t vecs[$];
  vec_t v;

  task automatic addVec(input logic wr, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] rr, input logic [15:0] ra,
                        input logic eWe, input logic eRe, input logic [3:0] eAck,
                        input logic [3:0] eVld, input logic [127:0] eData);
    vec_t t;
    t.wrReq = wr; t.wrAddr = wa; t.wrData = wd; t.rdReq = rr; t.rdA = ra;
    t.eWe = eWe; t.eRe = eRe; t.eAck = eAck; t.eVld = eVld; t.eData = eData;
    vecs.push_back(t);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] rr, input logic [15:0] ra);
    bus.wrReq    = wr;
    bus.wrAddr   = wa;
    bus.wrData   = wd;
    bus.rdReq    = rr;
    bus.rdAddr_0 = ra[3:0];
    bus.rdAddr_1 = ra[7:4];
    bus.rdAddr_2 = ra[11:8];
    bus.rdAddr_3 = ra[15:12];
  endtask

  function automatic logic [31:0] ctrl();
    return {20'd0, ramChipSelect, ramWriteEnable, ramReadEnable, bus.wrAck, bus.rdAck, bus.rdValid};
  endfunction

  function automatic logic [31:0] expCtrl(input logic we, input logic re,
                                          input logic [3:0] ack, input logic [3:0] vld);
    return {20'd0, we | re, we, re, we, ack, vld};
  endfunction

  function automatic logic [31:0] rdDataOf(input int i);
    case (i)
      0:       return bus.rdData_0;
      1:       return bus.rdData_1;
      2:       return bus.rdData_2;
      default: return bus.rdData_3;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | i;

    // Write alone, then read of the same line returns the new data
    addVec(1, 4'd5, 32'hDEADBEEF, 4'b0000, 16'h0000, 1, 0, 4'b0000, 4'b0000, 128'd0);
    addVec(0, 4'd0, 32'h0,        4'b0100, 16'h0500, 0, 1, 4'b0100, 4'b0000, 128'd0);
    addVec(0, 4'd0, 32'h0,        4'b0000, 16'h0000, 0, 0, 4'b0000, 4'b0100,
           {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    // All four ports in one shared read
    addVec(0, 4'd0, 32'h0,        4'b1111, 16'h4321, 0, 1, 4'b1111, 4'b0000, 128'd0);
    addVec(0, 4'd0, 32'h0,        4'b0000, 16'h0000, 0, 0, 4'b0000, 4'b1111,
           {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001});
    // Request held through its ack cycle is not granted twice
    addVec(0, 4'd0, 32'h0,        4'b0001, 16'h0007, 0, 1, 4'b0001, 4'b0000, 128'd0);
    addVec(0, 4'd0, 32'h0,        4'b0001, 16'h0007, 0, 0, 4'b0000, 4'b0001,
           {96'h0, 32'hA0000007});
    addVec(0, 4'd0, 32'h0,        4'b0000, 16'h0000, 0, 0, 4'b0000, 4'b0000, 128'd0);
    // Write waits through three reads, then wins; ordering old/new data around it
    addVec(1, 4'd9, 32'h12345678, 4'b0001, 16'h0009, 0, 1, 4'b0001, 4'b0000, 128'd0);
    addVec(1, 4'd9, 32'h12345678, 4'b0010, 16'h0090, 0, 1, 4'b0010, 4'b0001,
           {96'h0, 32'hA0000009});
    addVec(1, 4'd9, 32'h12345678, 4'b0001, 16'h0003, 0, 1, 4'b0001, 4'b0010,
           {64'h0, 32'hA0000009, 32'h0});
    addVec(1, 4'd9, 32'h12345678, 4'b0010, 16'h0090, 1, 0, 4'b0000, 4'b0001,
           {96'h0, 32'hA0000003});
    addVec(0, 4'd0, 32'h0,        4'b0010, 16'h0090, 0, 1, 4'b0010, 4'b0000, 128'd0);
    addVec(0, 4'd0, 32'h0,        4'b0000, 16'h0000, 0, 0, 4'b0000, 4'b0010,
           {64'h0, 32'h12345678, 32'h0});

    // Reset held two cycles with every requester active
    Reset = 1'b1;
    drive(1, 4'd14, 32'hC0FFEE00, 4'b1111, 16'h0000);
    for (int c = 0; c < 2; c++) begin
      @(posedge Clk); #1;
      check($sformatf("reset%0d ctrl", c), ctrl(), 32'd0);
    end
    check("reset wrAddr", {28'd0, ramWriteAddr}, 32'd0);
    check("reset wrData", ramDataIn, 32'd0);
    check("reset rdAddr3", {28'd0, ramReadAddr_3}, 32'd0);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    check("post-reset read", ctrl(), expCtrl(0, 1, 4'b1111, 4'b0000));
    @(negedge Clk); drive(1, 4'd14, 32'hC0FFEE00, 4'b0000, 16'h0000);
    @(posedge Clk); #1;
    check("post-reset write", ctrl(), expCtrl(1, 0, 4'b0000, 4'b1111));
    check("post-reset data0", rdDataOf(0), 32'hA0000000);
    check("post-reset data3", rdDataOf(3), 32'hA0000000);
    check("post-reset wrAddr", {28'd0, ramWriteAddr}, 32'd14);
    check("post-reset wrData", ramDataIn, 32'hC0FFEE00);
    @(negedge Clk); drive(0, 4'd0, 32'h0, 4'b0000, 16'h0000);
    @(posedge Clk); #1;
    check("post-reset idle", ctrl(), 32'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      @(negedge Clk);
      drive(v.wrReq, v.wrAddr, v.wrData, v.rdReq, v.rdA);
      @(posedge Clk); #1;
      check($sformatf("vec%0d ctrl", k), ctrl(), expCtrl(v.eWe, v.eRe, v.eAck, v.eVld));
      for (int i = 0; i < 4; i++) begin
        if (v.eVld[i]) check($sformatf("vec%0d rdData_%0d", k, i), rdDataOf(i), v.eData[32*i +: 32]);
      end
      if (v.eWe) begin
        check($sformatf("vec%0d ramWriteAddr", k), {28'd0, ramWriteAddr}, {28'd0, v.wrAddr});
        check($sformatf("vec%0d ramDataIn", k), ramDataIn, v.wrData);
      end
    end

    // Reset landing on a read cycle drops the in-flight read
    @(negedge Clk); drive(0, 4'd0, 32'h0, 4'b0001, 16'h0002);
    @(posedge Clk); #1;
    check("t6 read issued", ctrl(), expCtrl(0, 1, 4'b0001, 4'b0000));
    @(negedge Clk); Reset = 1'b1; drive(0, 4'd0, 32'h0, 4'b0000, 16'h0000);
    @(posedge Clk); #1;
    check("t6 reset drop", ctrl(), 32'd0);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    check("t6 after release", ctrl(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
